// File: rtl/fix_field_sequencer.sv
// fix_field_sequencer: queues FIX tag/value fields and drives the byte
// serializer one field at a time, closing each message with the "10=" trailer.
module fix_field_sequencer #(
    parameter int unsigned VALUE_WIDTH = 64,
    parameter int unsigned T_SIZE      = 5,
    parameter int unsigned SIZE        = 64,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en_i,
    input  logic [31:0]            wr_tag_i,
    input  logic [VALUE_WIDTH-1:0] wr_val_i,
    input  logic [T_SIZE-1:0]      wr_tsize_i,
    input  logic [SIZE-1:0]        wr_vsize_i,
    input  logic                   wr_last_i,
    output logic                   full_o,
    output logic                   tag_valid_o,
    output logic                   val_valid_o,
    output logic [31:0]            tag_o,
    output logic [VALUE_WIDTH-1:0] val_o,
    output logic [T_SIZE-1:0]      t_size_o,
    output logic [SIZE-1:0]        v_size_o,
    output logic                   checksum_o,
    input  logic                   done_i,
    input  logic                   end_i,
    output logic                   busy_o,
    output logic                   msg_done_o,
    output logic [7:0]             field_cnt_o,
    output logic [15:0]            msg_cnt_o,
    output logic                   ovf_o,
    output logic                   timeout_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_TAG_ISS, ST_TAG_WAIT,
        ST_VAL_ISS, ST_VAL_WAIT, ST_TRL_ISS, ST_TRL_WAIT
    } state_t;

    // Field queue storage
    logic [31:0]            r_mem_tag   [DEPTH];
    logic [VALUE_WIDTH-1:0] r_mem_val   [DEPTH];
    logic [T_SIZE-1:0]      r_mem_tsize [DEPTH];
    logic [SIZE-1:0]        r_mem_vsize [DEPTH];
    logic                   r_mem_last  [DEPTH];

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;

    state_t                 r_state;
    logic [TW-1:0]          r_wait_cnt;
    logic                   r_tag_valid;
    logic                   r_val_valid;
    logic                   r_msg_done;
    logic [31:0]            r_tag;
    logic [VALUE_WIDTH-1:0] r_val;
    logic [T_SIZE-1:0]      r_tsize;
    logic [SIZE-1:0]        r_vsize;
    logic                   r_checksum;
    logic [7:0]             r_field_cnt;
    logic [15:0]            r_msg_cnt;
    logic                   r_timeout;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_expire;
    logic          w_wait_max;
    logic [CW-1:0] w_count_nxt;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = wr_en_i && (!w_full || w_pop);
    assign w_wait_max = (r_wait_cnt == TW'(TIMEOUT - 1));

    // Response timeout detection and queue pop (normal completion or dropped head)
    always_comb begin
        w_expire = 1'b0;
        w_pop    = 1'b0;
        case (r_state)
            ST_TAG_WAIT: begin
                w_expire = !done_i && w_wait_max;
                w_pop    = w_expire;
            end
            ST_VAL_WAIT: begin
                w_expire = !done_i && w_wait_max;
                w_pop    = done_i || w_expire;
            end
            ST_TRL_WAIT: begin
                w_expire = !end_i && w_wait_max;
            end
            default: ;
        endcase
    end

    // Queue occupancy after this cycle's push/pop
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Queue payload write (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_tag[r_wptr]   <= wr_tag_i;
            r_mem_val[r_wptr]   <= wr_val_i;
            r_mem_tsize[r_wptr] <= wr_tsize_i;
            r_mem_vsize[r_wptr] <= wr_vsize_i;
            r_mem_last[r_wptr]  <= wr_last_i;
        end
    end

    // Queue pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            if (wr_en_i && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    // Sequencing FSM with registered handshake pulses, operands and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= '0;
            r_tag_valid <= 1'b0;
            r_val_valid <= 1'b0;
            r_msg_done  <= 1'b0;
            r_tag       <= '0;
            r_val       <= '0;
            r_tsize     <= '0;
            r_vsize     <= '0;
            r_checksum  <= 1'b0;
            r_field_cnt <= '0;
            r_msg_cnt   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_tag_valid <= 1'b0;
            r_val_valid <= 1'b0;
            r_msg_done  <= 1'b0;
            r_wait_cnt  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_tag      <= r_mem_tag[r_rptr];
                    r_val      <= r_mem_val[r_rptr];
                    r_tsize    <= r_mem_tsize[r_rptr];
                    r_vsize    <= r_mem_vsize[r_rptr];
                    r_checksum <= 1'b0;
                    r_state    <= ST_TAG_ISS;
                end
                ST_TAG_ISS: begin
                    r_tag_valid <= 1'b1;
                    r_state     <= ST_TAG_WAIT;
                end
                ST_TAG_WAIT: begin
                    if (done_i) begin
                        r_state <= ST_VAL_ISS;
                    end else if (w_expire) begin
                        r_timeout   <= 1'b1;
                        r_field_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                ST_VAL_ISS: begin
                    r_val_valid <= 1'b1;
                    r_state     <= ST_VAL_WAIT;
                end
                ST_VAL_WAIT: begin
                    if (done_i) begin
                        if (r_field_cnt != 8'hFF) r_field_cnt <= r_field_cnt + 8'd1;
                        if (r_mem_last[r_rptr])    r_state <= ST_TRL_ISS;
                        else if (w_count_nxt != '0) r_state <= ST_LOAD;
                        else                        r_state <= ST_IDLE;
                    end else if (w_expire) begin
                        r_timeout   <= 1'b1;
                        r_field_cnt <= '0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                ST_TRL_ISS: begin
                    r_tag       <= 32'h0000_3031;
                    r_tsize     <= T_SIZE'(2'b11);
                    r_checksum  <= 1'b1;
                    r_tag_valid <= 1'b1;
                    r_state     <= ST_TRL_WAIT;
                end
                ST_TRL_WAIT: begin
                    if (end_i) begin
                        r_msg_done  <= 1'b1;
                        r_msg_cnt   <= r_msg_cnt + 16'd1;
                        r_field_cnt <= '0;
                        r_checksum  <= 1'b0;
                        r_state     <= (w_count_nxt != '0) ? ST_LOAD : ST_IDLE;
                    end else if (w_expire) begin
                        r_timeout   <= 1'b1;
                        r_field_cnt <= '0;
                        r_checksum  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign full_o      = w_full;
    assign busy_o      = (r_state != ST_IDLE);
    assign tag_valid_o = r_tag_valid;
    assign val_valid_o = r_val_valid;
    assign msg_done_o  = r_msg_done;
    assign tag_o       = r_tag;
    assign val_o       = r_val;
    assign t_size_o    = r_tsize;
    assign v_size_o    = r_vsize;
    assign checksum_o  = r_checksum;
    assign field_cnt_o = r_field_cnt;
    assign msg_cnt_o   = r_msg_cnt;
    assign ovf_o       = r_ovf;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_fix_field_sequencer.sv
// Directed self-checking bench for fix_field_sequencer with a small serializer model.
module tb_fix_field_sequencer;

    logic        clk;
    logic        rst;
    logic        wr_en_i;
    logic [31:0] wr_tag_i;
    logic [63:0] wr_val_i;
    logic [4:0]  wr_tsize_i;
    logic [63:0] wr_vsize_i;
    logic        wr_last_i;
    logic        full_o;
    logic        tag_valid_o;
    logic        val_valid_o;
    logic [31:0] tag_o;
    logic [63:0] val_o;
    logic [4:0]  t_size_o;
    logic [63:0] v_size_o;
    logic        checksum_o;
    logic        done_i;
    logic        end_i;
    logic        busy_o;
    logic        msg_done_o;
    logic [7:0]  field_cnt_o;
    logic [15:0] msg_cnt_o;
    logic        ovf_o;
    logic        timeout_o;

    fix_field_sequencer dut (
        .clk(clk), .rst(rst),
        .wr_en_i(wr_en_i), .wr_tag_i(wr_tag_i), .wr_val_i(wr_val_i),
        .wr_tsize_i(wr_tsize_i), .wr_vsize_i(wr_vsize_i), .wr_last_i(wr_last_i),
        .full_o(full_o), .tag_valid_o(tag_valid_o), .val_valid_o(val_valid_o),
        .tag_o(tag_o), .val_o(val_o), .t_size_o(t_size_o), .v_size_o(v_size_o),
        .checksum_o(checksum_o), .done_i(done_i), .end_i(end_i), .busy_o(busy_o),
        .msg_done_o(msg_done_o), .field_cnt_o(field_cnt_o), .msg_cnt_o(msg_cnt_o),
        .ovf_o(ovf_o), .timeout_o(timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Serializer model controls (written only by the stimulus process)
    logic stall      = 1'b0;
    logic hold_val   = 1'b0;
    logic trl_extra  = 1'b0;
    int   trl_dly    = 5;

    // Event log written only by the model: 1=tag, 2=value, 3=trailer tag
    int         n_ev = 0;
    int         n_tag = 0;
    int         n_val = 0;
    int         n_mdone = 0;
    logic [1:0] ev_kind [256];
    logic [31:0] ev_tag [256];
    logic [4:0] ev_ts   [256];
    logic [7:0] ev_fc   [256];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Serializer model: done_i 2 cycles after each pulse, end_i trl_dly after trailer
    initial begin
        int cnt_d;
        int cnt_e;
        cnt_d  = 0;
        cnt_e  = 0;
        done_i = 1'b0;
        end_i  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            done_i = 1'b0;
            end_i  = 1'b0;
            if (cnt_d > 0) begin cnt_d--; if (cnt_d == 0) done_i = 1'b1; end
            if (cnt_e > 0) begin cnt_e--; if (cnt_e == 0) end_i = 1'b1; end
            if (msg_done_o) n_mdone++;
            if (tag_valid_o) begin
                if (n_ev < 256) begin
                    ev_kind[n_ev] = checksum_o ? 2'd3 : 2'd1;
                    ev_tag[n_ev]  = tag_o;
                    ev_ts[n_ev]   = t_size_o;
                    ev_fc[n_ev]   = field_cnt_o;
                end
                n_ev++;
                n_tag++;
                if (!stall) begin
                    if (checksum_o) begin
                        cnt_e = trl_dly;
                        if (trl_extra) cnt_d = 2;
                    end else begin
                        cnt_d = 2;
                    end
                end
            end
            if (val_valid_o) begin
                if (n_ev < 256) begin
                    ev_kind[n_ev] = 2'd2;
                    ev_tag[n_ev]  = tag_o;
                    ev_ts[n_ev]   = t_size_o;
                    ev_fc[n_ev]   = field_cnt_o;
                end
                n_ev++;
                n_val++;
                if (!stall && !hold_val) cnt_d = 2;
            end
        end
    end

    task automatic push(input logic [31:0] tg, input logic [63:0] vl,
                        input logic [4:0] ts, input logic [63:0] vs, input logic lst);
        wr_tag_i   = tg;
        wr_val_i   = vl;
        wr_tsize_i = ts;
        wr_vsize_i = vs;
        wr_last_i  = lst;
        wr_en_i    = 1'b1;
        @(posedge clk);
        #1;
        wr_en_i    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_msg(input int target, input string name);
        for (int i = 0; i < 400 && int'(msg_cnt_o) != target; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, 64'(msg_cnt_o), 64'(target));
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic wait_val(input string name);
        int i;
        for (i = 0; i < 100 && !val_valid_o; i++) begin
            @(posedge clk);
            #1;
        end
        chk(name, 64'(val_valid_o), 64'd1);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_tag"},   64'(tag_o),       64'd0);
        chk({pfx, "_val"},   val_o,            64'd0);
        chk({pfx, "_tsz"},   64'(t_size_o),    64'd0);
        chk({pfx, "_vsz"},   v_size_o,         64'd0);
        chk({pfx, "_cs"},    64'(checksum_o),  64'd0);
        chk({pfx, "_busy"},  64'(busy_o),      64'd0);
        chk({pfx, "_full"},  64'(full_o),      64'd0);
        chk({pfx, "_fcnt"},  64'(field_cnt_o), 64'd0);
        chk({pfx, "_mcnt"},  64'(msg_cnt_o),   64'd0);
        chk({pfx, "_ovf"},   64'(ovf_o),       64'd0);
        chk({pfx, "_tmo"},   64'(timeout_o),   64'd0);
        chk({pfx, "_pulse"}, 64'({tag_valid_o, val_valid_o, msg_done_o}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        int b;
        int k;
        int t0;
        int m0;
        rst        = 1'b1;
        wr_en_i    = 1'b0;
        wr_tag_i   = '0;
        wr_val_i   = '0;
        wr_tsize_i = '0;
        wr_vsize_i = '0;
        wr_last_i  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("rst");

        // One field "35=A", then trailer
        #1; b = n_ev;
        push(32'h0000_3533, 64'h41, 5'b00011, 64'h1, 1'b1);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (tag_valid_o) break;
        end
        chk("t1_tag_latency", 64'(k), 64'd3);
        wait_msg(1, "t1_msg_cnt");
        chk("t1_ev0_kind", 64'(ev_kind[b]),   64'd1);
        chk("t1_ev0_tag",  64'(ev_tag[b]),    64'h3533);
        chk("t1_ev0_tsz",  64'(ev_ts[b]),     64'h3);
        chk("t1_ev1_kind", 64'(ev_kind[b+1]), 64'd2);
        chk("t1_ev2_kind", 64'(ev_kind[b+2]), 64'd3);
        chk("t1_trl_tag",  64'(ev_tag[b+2]),  64'h3031);
        chk("t1_trl_tsz",  64'(ev_ts[b+2]),   64'h3);
        chk("t1_nev",      64'(n_ev - b),     64'd3);
        chk("t1_mdone",    64'(n_mdone),      64'd1);
        chk("t1_fcnt",     64'(field_cnt_o),  64'd0);
        chk("t1_cs_clr",   64'(checksum_o),   64'd0);
        chk("t1_busy",     64'(busy_o),       64'd0);

        // Three fields, last on the third
        b = n_ev; t0 = n_tag; k = n_val; m0 = n_mdone;
        push(32'h0000_3934, 64'h30_31, 5'b00011, 64'h3, 1'b0);
        push(32'h0000_3634, 64'h32,    5'b00011, 64'h1, 1'b0);
        push(32'h0000_3135, 64'h33,    5'b00011, 64'h1, 1'b1);
        wait_msg(2, "t2_msg_cnt");
        chk("t2_tags",   64'(n_tag - t0),   64'd4);
        chk("t2_vals",   64'(n_val - k),    64'd3);
        chk("t2_fc1",    64'(ev_fc[b+2]),   64'd1);
        chk("t2_fc2",    64'(ev_fc[b+4]),   64'd2);
        chk("t2_fc3",    64'(ev_fc[b+6]),   64'd3);
        chk("t2_trl",    64'(ev_kind[b+6]), 64'd3);
        chk("t2_tag3",   64'(ev_tag[b+4]),  64'h3135);
        chk("t2_mdone",  64'(n_mdone - m0), 64'd1);
        chk("t2_fcnt",   64'(field_cnt_o),  64'd0);

        // done_i during trailer wait must not close the message
        trl_dly = 20; trl_extra = 1'b1; m0 = n_mdone;
        push(32'h0000_3533, 64'h42, 5'b00011, 64'h1, 1'b1);
        for (int i = 0; i < 60 && !(tag_valid_o && checksum_o); i++) begin
            @(posedge clk);
            #1;
        end
        chk("t3_trl_seen", 64'(tag_valid_o && checksum_o), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("t3_busy",  64'(busy_o),       64'd1);
        chk("t3_cs",    64'(checksum_o),   64'd1);
        chk("t3_mcnt",  64'(msg_cnt_o),    64'd2);
        chk("t3_nodone", 64'(n_mdone - m0), 64'd0);
        wait_msg(3, "t3_msg_cnt");
        trl_dly = 5; trl_extra = 1'b0;

        // Withheld value done: timeout drops only the head entry
        hold_val = 1'b1;
        push(32'h0000_3131, 64'h43, 5'b00011, 64'h1, 1'b0);
        push(32'h0000_3434, 64'h44, 5'b00011, 64'h1, 1'b1);
        wait_val("t4_val_seen");
        repeat (254) @(posedge clk);
        #1;
        chk("t4_tmo_early", 64'(timeout_o), 64'd0);
        chk("t4_busy_wait", 64'(busy_o),    64'd1);
        @(posedge clk);
        #1;
        chk("t4_tmo",       64'(timeout_o),   64'd1);
        chk("t4_idle",      64'(busy_o),      64'd0);
        chk("t4_fcnt",      64'(field_cnt_o), 64'd0);
        hold_val = 1'b0;
        #1; b = n_ev;
        wait_msg(4, "t4_msg_cnt");
        chk("t4_next_tag", 64'(ev_tag[b]),  64'h3434);
        chk("t4_nev",      64'(n_ev - b),   64'd3);
        chk("t4_fc_trl",   64'(ev_fc[b+2]), 64'd1);

        // Overflow with stalled serializer
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) push(32'h0000_3034 + 32'(i), 64'h45, 5'b00011, 64'h1, 1'b1);
        chk("t5_full8",  64'(full_o), 64'd1);
        chk("t5_ovf8",   64'(ovf_o),  64'd0);
        push(32'h0000_3939, 64'h46, 5'b00011, 64'h1, 1'b1);
        chk("t5_full9",  64'(full_o), 64'd1);
        chk("t5_ovf9",   64'(ovf_o),  64'd1);
        do_reset();
        stall = 1'b0;
        chk("t5_rst_full", 64'(full_o), 64'd0);
        chk("t5_rst_ovf",  64'(ovf_o),  64'd0);

        // Reset in VAL_WAIT with three entries queued
        hold_val = 1'b1;
        push(32'h0000_3135, 64'h47, 5'b00011, 64'h1, 1'b0);
        push(32'h0000_3235, 64'h48, 5'b00011, 64'h1, 1'b0);
        push(32'h0000_3335, 64'h49, 5'b00011, 64'h1, 1'b0);
        wait_val("t6_val_seen");
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        check_zero("t6");
        #1; t0 = n_tag;
        hold_val = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_no_tag",  64'(n_tag - t0), 64'd0);
        chk("t6_idle",    64'(busy_o),     64'd0);
        push(32'h0000_3533, 64'h4A, 5'b00011, 64'h1, 1'b1);
        wait_msg(1, "t6_msg_cnt");
        chk("t6_val_o", val_o, 64'h4A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
